sevenseg_capture: RTL and testbench

Reads back a time-multiplexed, active-low seven-segment display bus and reconstructs the hex nibble shown on each digit. It is the inverse of the hex-to-segment encoder and sits beside the display driver as a self-check and monitor tap. A digit is decoded only after its anode and segment lines have held steady for a programmable number of cycles. Results are published atomically once every digit has been captured.

---
 rtl/sevenseg_capture.sv | 246 ++++++++++++++++++++++++
 tb/tb_sevenseg_capture.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_capture.sv
// sevenseg_capture
//   Monitor tap for a time-multiplexed, active-low seven-segment display bus.
//   It recovers the hex nibble shown on each digit. A digit is decoded only
//   after its anode/segment pair has held steady for STABLE_CYCLES cycles.
//   A completed frame (every digit captured) is published to the outputs
//   atomically.
//
//   Optional feature macro: SEVENSEG_CAPTURE_ERRCNT_EN adds the err_count port.
//
// Parameters
//   DIGITS        number of multiplexed digits (1..8)
//   STABLE_CYCLES consecutive unchanged cycles before capture (>= 2)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   an_n         active-low digit enables; exactly one low bit selects a digit
//   seg_n        active-low segments, bit6..bit0 = A..G
//   value        decoded nibbles, digit i in [4i+3:4i]
//   blank        digit i showed all segments off
//   invalid      digit i showed a non-hex, non-blank pattern
//   frame_valid  one-cycle pulse in the cycle value/blank/invalid change
//   err_count    (SEVENSEG_CAPTURE_ERRCNT_EN only) saturating error counter
//   dbg_state    current capture FSM state (0 idle, 1 settle, 2 captured)
//
// Output protocol: frame_valid has no back-pressure. It is high for exactly
// one cycle. In that cycle value/blank/invalid already hold the new frame, and
// they stay unchanged until the next pulse.
module sevenseg_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     an_n,
  input  logic [6:0]            seg_n,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     invalid,
  output logic                  frame_valid,
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
  output logic [7:0]            err_count,
`endif
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETTLE   = 2'd1,
    S_CAPTURED = 2'd2
  } state_t;

  // Returns {invalid, blank, nibble}; nibble is 0 for blank or invalid.
  function automatic logic [5:0] decode(input logic [6:0] s);
    logic [5:0] r;
    case (s)
      7'b0000001: r = 6'h00;
      7'b1001111: r = 6'h01;
      7'b0010010: r = 6'h02;
      7'b0000110: r = 6'h03;
      7'b1001100: r = 6'h04;
      7'b0100100: r = 6'h05;
      7'b0100000: r = 6'h06;
      7'b0001111: r = 6'h07;
      7'b0000000: r = 6'h08;
      7'b0000100: r = 6'h09;
      7'b0001000: r = 6'h0A;
      7'b1100000: r = 6'h0B;
      7'b0110001: r = 6'h0C;
      7'b1000010: r = 6'h0D;
      7'b0110000: r = 6'h0E;
      7'b0111000: r = 6'h0F;
      7'b1111111: r = 6'b01_0000;
      default:    r = 6'b10_0000;
    endcase
    return r;
  endfunction

  logic [DIGITS-1:0]   r_an_q, p_an_q;
  logic [6:0]          r_seg_q, p_seg_q;
  logic [CNT_W-1:0]    stable_cnt_q, stable_cnt_d;
  state_t              state_q, state_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic                pending_q, pending_d;
  logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
  logic [DIGITS-1:0]   shadow_inv_q, shadow_inv_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [DIGITS-1:0]   invalid_q, invalid_d;
  logic                frame_valid_q, frame_valid_d;
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
  logic [7:0]          err_q, err_d;
`endif

  logic [3:0]       zero_cnt;
  logic [IDX_W-1:0] low_idx;
  logic             one_hot;
  logic             changed;
  logic             capture;
  logic [5:0]       dec;

  // Anode analysis, stability counter and FSM
  always_comb begin
    zero_cnt = '0;
    low_idx  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!r_an_q[i]) begin
        zero_cnt = zero_cnt + 4'd1;
        low_idx  = IDX_W'(i);
      end
    end
    one_hot = (zero_cnt == 4'd1);
    changed = (r_an_q != p_an_q) || (r_seg_q != p_seg_q);

    if (!one_hot || changed) begin
      stable_cnt_d = '0;
    end else if (stable_cnt_q != CNT_MAX) begin
      stable_cnt_d = stable_cnt_q + CNT_W'(1);
    end else begin
      stable_cnt_d = stable_cnt_q;
    end

    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (one_hot) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (!one_hot) begin
          state_d = S_IDLE;
        end else if (changed) begin
          state_d = S_SETTLE;
        end else if (stable_cnt_q == CNT_MAX) begin
          capture = 1'b1;
          state_d = S_CAPTURED;
        end
      end
      S_CAPTURED: begin
        if (!one_hot) begin
          state_d = S_IDLE;
        end else if (changed) begin
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shadow capture, frame completion and output publish
  always_comb begin
    dec            = decode(r_seg_q);
    shadow_val_d   = shadow_val_q;
    shadow_blank_d = shadow_blank_q;
    shadow_inv_d   = shadow_inv_q;
    // A publishing edge starts a fresh frame, and a capture on that same
    // edge is the first member of the new frame.
    seen_d         = pending_q ? '0 : seen_q;
    if (capture) begin
      shadow_val_d[4*low_idx +: 4] = dec[3:0];
      shadow_blank_d[low_idx]      = dec[4];
      shadow_inv_d[low_idx]        = dec[5];
      seen_d[low_idx]              = 1'b1;
    end
    // seen is only ever all ones in the cycle that pending is high, so this
    // flags the edge where the set completes.
    pending_d = &seen_d;

    value_d       = value_q;
    blank_d       = blank_q;
    invalid_d     = invalid_q;
    frame_valid_d = pending_q;
    if (pending_q) begin
      value_d   = shadow_val_q;
      blank_d   = shadow_blank_q;
      invalid_d = shadow_inv_q;
    end
  end

`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
  always_comb begin
    err_d = err_q;
    if (((capture && dec[5]) || ((zero_cnt >= 4'd2) && changed)) &&
        (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an_q         <= '1;
      p_an_q         <= '1;
      r_seg_q        <= '1;
      p_seg_q        <= '1;
      stable_cnt_q   <= '0;
      state_q        <= S_IDLE;
      seen_q         <= '0;
      pending_q      <= 1'b0;
      shadow_val_q   <= '0;
      shadow_blank_q <= '0;
      shadow_inv_q   <= '0;
      value_q        <= '0;
      blank_q        <= '1;
      invalid_q      <= '0;
      frame_valid_q  <= 1'b0;
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
      err_q          <= '0;
`endif
    end else begin
      r_an_q         <= an_n;
      p_an_q         <= r_an_q;
      r_seg_q        <= seg_n;
      p_seg_q        <= r_seg_q;
      stable_cnt_q   <= stable_cnt_d;
      state_q        <= state_d;
      seen_q         <= seen_d;
      pending_q      <= pending_d;
      shadow_val_q   <= shadow_val_d;
      shadow_blank_q <= shadow_blank_d;
      shadow_inv_q   <= shadow_inv_d;
      value_q        <= value_d;
      blank_q        <= blank_d;
      invalid_q      <= invalid_d;
      frame_valid_q  <= frame_valid_d;
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
      err_q          <= err_d;
`endif
    end
  end

  assign value       = value_q;
  assign blank       = blank_q;
  assign invalid     = invalid_q;
  assign frame_valid = frame_valid_q;
  assign dbg_state   = state_q;
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
  assign err_count   = err_q;
`endif

endmodule

// File: tb/tb_sevenseg_capture.sv
// Testbench for sevenseg_capture (DIGITS=4, STABLE_CYCLES=8).
module tb_sevenseg_capture;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SETTLE   = 2'd1;
  localparam logic [1:0] ST_CAPTURED = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic [15:0] value;
  logic [3:0]  blank;
  logic [3:0]  invalid;
  logic        frame_valid;
  logic [1:0]  dbg_state;
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sevenseg_capture #(.DIGITS(4), .STABLE_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .value       (value),
    .blank       (blank),
    .invalid     (invalid),
    .frame_valid (frame_valid),
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
    .err_count   (err_count),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_bad = 0;
  int          cap_states = 0;
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  logic [6:0]  glyph[16];

  typedef struct {
    logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    logic [15:0] val;
    logic [3:0]  blk;
    logic [3:0]  inv;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (frame_valid) got_q.push_back({invalid, blank, value});
    if (dbg_state == ST_CAPTURED) cap_states++;
  endtask

  task automatic show(input int d, input logic [6:0] s, input int cycles);
    an_n  = ~(4'b0001 << d);
    seg_n = s;
    repeat (cycles) step();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    an_n  = 4'hF;
    seg_n = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    got_q.delete();
    cap_states = 0;
  endtask

  task automatic check_frame(input string name, input logic [23:0] want);
    exp_q.push_back(want);
    check({name, "_frames"}, got_q.size(), 1);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check(name, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    glyph = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Back-to-back frames cover all 16 glyphs, then blank/invalid cases.
    vecs[0] = '{{glyph[3],  glyph[2],  glyph[1], glyph[0]},  16'h3210, 4'h0, 4'h0};
    vecs[1] = '{{glyph[7],  glyph[6],  glyph[5], glyph[4]},  16'h7654, 4'h0, 4'h0};
    vecs[2] = '{{glyph[11], glyph[10], glyph[9], glyph[8]},  16'hBA98, 4'h0, 4'h0};
    vecs[3] = '{{glyph[15], glyph[14], glyph[13], glyph[12]}, 16'hFEDC, 4'h0, 4'h0};
    vecs[4] = '{{7'b1010101, glyph[12], 7'b1111111, glyph[2]}, 16'h0C02, 4'b0010, 4'b1000};
    vecs[5] = '{{7'h7F, 7'h7F, 7'h7F, 7'h7F},                 16'h0000, 4'hF, 4'h0};

    do_reset();

    // Reset state
    check("rst_value",   32'(value), 0);
    check("rst_blank",   32'(blank), 32'hF);
    check("rst_invalid", 32'(invalid), 0);
    check("rst_fv",      32'(frame_valid), 0);
    check("rst_state",   32'(dbg_state), 32'(ST_IDLE));
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
    check("rst_err",     32'(err_count), 0);
`endif

    // Full frame 1,A,7,F with capture and publish latency
    an_n  = 4'b1110;
    seg_n = glyph[1];
    repeat (9) step();
    check("lat_settle",  32'(dbg_state), 32'(ST_SETTLE));
    step();
    check("lat_capture", 32'(dbg_state), 32'(ST_CAPTURED));
    repeat (10) step();
    show(1, glyph[10], 20);
    show(2, glyph[7], 20);
    an_n  = 4'b0111;
    seg_n = glyph[15];
    repeat (10) step();
    check("fv_before", 32'(frame_valid), 0);
    step();
    check("fv_pulse", 32'(frame_valid), 1);
    check("fv_value", 32'(value), 32'hF7A1);
    step();
    check("fv_after", 32'(frame_valid), 0);
    repeat (8) step();
    check_frame("full", {4'h0, 4'h0, 16'hF7A1});

    // Glitch rejection on digit 2
    do_reset();
    an_n  = 4'b1011;
    seg_n = glyph[3];
    repeat (7) step();
    seg_n = glyph[8];
    step();
    seg_n = glyph[3];
    repeat (9) step();
    check("glitch_no_early", 32'(cap_states), 0);
    check("glitch_settle",   32'(dbg_state), 32'(ST_SETTLE));
    step();
    check("glitch_capture",  32'(dbg_state), 32'(ST_CAPTURED));

    // Multi-anode then no-anode
    do_reset();
    an_n  = 4'b0011;
    seg_n = glyph[0];
    repeat (30) step();
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
    check("multi_err_a", 32'(err_count), 1);
`endif
    an_n = 4'b1111;
    repeat (30) step();
    check("multi_frames",  got_q.size(), 0);
    check("multi_capture", 32'(cap_states), 0);
    check("multi_state",   32'(dbg_state), 32'(ST_IDLE));
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
    check("multi_err_b", 32'(err_count), 1);
`endif

    // Recapture, then reset mid-frame
    do_reset();
    show(0, glyph[5], 12);
    show(0, glyph[9], 12);
    show(1, glyph[1], 12);
    show(2, glyph[2], 12);
    show(3, glyph[3], 12);
    check_frame("recap", {8'h00, 16'h3219});
    check("recap_nib0", 32'(value[3:0]), 9);
    show(0, glyph[4], 12);
    show(1, glyph[4], 12);
    rst = 1'b1;
    #1;
    check("mid_rst_value",   32'(value), 0);
    check("mid_rst_blank",   32'(blank), 32'hF);
    check("mid_rst_invalid", 32'(invalid), 0);
    check("mid_rst_state",   32'(dbg_state), 32'(ST_IDLE));
    an_n  = 4'hF;
    seg_n = 7'h7F;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    show(2, glyph[6], 12);
    show(3, glyph[7], 12);
    check("post_rst_noframe", got_q.size(), 0);
    show(0, glyph[8], 12);
    show(1, glyph[8], 12);
    check_frame("post_rst", {8'h00, 16'h7688});

    // Table-driven frames
    do_reset();
    for (int v = 0; v < 6; v++) begin
      for (int d = 0; d < 4; d++) begin
        logic [6:0] s;
        s = vecs[v].segs[7*d +: 7];
        show(d, s, 12);
      end
      check_frame($sformatf("vec%0d", v), {vecs[v].inv, vecs[v].blk, vecs[v].val});
    end
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
    check("table_err", 32'(err_count), 1);
`endif

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
